spoc64_controller: RTL and testbench



---
 rtl/spoc64_ctrl_pkg.sv | 43 ++++
 rtl/d_ff.sv | 18 +
 rtl/spoc64_controller.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_spoc64_controller.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spoc64_ctrl_pkg.sv
// SpoC-64 controller shared types.
// State encoding, bdi type codes and domain codes.
package spoc64_ctrl_pkg;

  typedef enum logic [4:0] {
    S_IDLE,
    S_LD_KEY,
    S_LD_NPUB,
    S_INIT_LOAD,
    S_INIT_PERM,
    S_INIT_LOCK,
    S_CLR,
    S_WAIT_BDI,
    S_TRUNC,
    S_OUT_HI,
    S_OUT_LO,
    S_ABSORB,
    S_PERM,
    S_FINAL_LOCK,
    S_FINAL_PERM,
    S_TAG_HI,
    S_TAG_LO,
    S_LD_TAG,
    S_VERIFY
  } state_t;

  localparam logic [2:0] T_NPUB = 3'b110;
  localparam logic [2:0] T_AD   = 3'b001;
  localparam logic [2:0] T_MSG  = 3'b010;
  localparam logic [2:0] T_TAG  = 3'b100;

  localparam logic [1:0] CW_AD  = 2'b01;
  localparam logic [1:0] CW_MSG = 2'b10;

  typedef struct packed {
    logic last;
    logic full;
    logic eoi;
    logic msg;
    logic partial;
  } blk_t;

endpackage

// File: rtl/d_ff.sv
// Enabled register primitive with synchronous reset.
// Used for small counters and edge-detect flops.
module d_ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/spoc64_controller.sv
// SpoC-64 AEAD control FSM.
// Sequences key/npub load, AD, PT/CT, tag output and verify.
module spoc64_controller
  import spoc64_ctrl_pkg::*;
#(
  parameter int KEY_WORDS  = 4,
  parameter int NPUB_WORDS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic       key_update,
  input  logic       bdi_valid,
  output logic       bdi_ready,
  input  logic [2:0] bdi_type,
  input  logic [2:0] bdi_size,
  input  logic       bdi_eot,
  input  logic       bdi_eoi,
  input  logic       decrypt_in,
  output logic       bdo_valid,
  input  logic       bdo_ready,
  output logic       end_of_block,
  output logic       msg_auth_valid,
  input  logic       msg_auth_ready,
  input  logic       done,
  input  logic       trunc_complete,
  input  logic       msg_auth,
  output logic       start,
  output logic       init_state,
  output logic       en_key,
  output logic       en_npub,
  output logic       en_bdi,
  output logic       clr_bdi,
  output logic       en_cum_size,
  output logic       en_trunc,
  output logic       init_trunc,
  output logic       bdi_complete,
  output logic       bdo_complete,
  output logic       en_state_in,
  output logic       sel_tag,
  output logic       init_lock,
  output logic       lock_tag_state,
  output logic       decrypt_reg,
  output logic       bdi_partial_reg,
  output logic [1:0] ctrl_word
);

  localparam logic [1:0] KEY_LAST  = 2'(KEY_WORDS - 1);
  localparam logic [1:0] NPUB_LAST = 2'(NPUB_WORDS - 1);

  state_t     state_q, state_d;
  logic       fresh_q;
  logic [1:0] cnt_q, cnt_d;
  logic       done_q, done_rise;
  logic [3:0] cum_q;
  blk_t       blk_q;
  logic       pad_q, tag_ph_q, dec_q;
  logic       acc, close, full_now, msg_now;
  logic       unused;

  // The auth result goes straight to the postprocessor.
  assign unused = msg_auth;

  assign msg_now   = bdi_type == T_MSG;
  assign acc       = state_q == S_WAIT_BDI && bdi_valid
                   && !tag_ph_q
                   && (bdi_type == T_AD || msg_now);
  assign close     = acc && (cnt_q == 2'd1 || bdi_eot);
  assign full_now  = cnt_q == 2'd1 && bdi_size == 3'd4;
  assign done_rise = done && !done_q;

  d_ff #(.W(2)) u_cnt (
    .clk(clk), .rst(rst), .en(1'b1),
    .d(cnt_d), .q(cnt_q)
  );

  d_ff #(.W(1)) u_done (
    .clk(clk), .rst(rst), .en(1'b1),
    .d(done), .q(done_q)
  );

  always_comb begin
    cnt_d = cnt_q;
    unique case (1'b1)
      state_q == S_LD_KEY:
        if (key_valid)
          cnt_d = cnt_q == KEY_LAST ? '0 : cnt_q + 2'd1;
      state_q == S_LD_NPUB:
        if (bdi_valid)
          cnt_d = cnt_q == NPUB_LAST ? '0 : cnt_q + 2'd1;
      state_q == S_WAIT_BDI:
        if (acc) cnt_d = close ? '0 : cnt_q + 2'd1;
      state_q == S_LD_TAG:
        if (bdi_valid)
          cnt_d = cnt_q == 2'd1 ? '0 : cnt_q + 2'd1;
      default: cnt_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      fresh_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fresh_q <= state_d != state_q;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (key_valid && key_update) state_d = S_LD_KEY;
        else if (bdi_valid && bdi_type == T_NPUB)
          state_d = S_LD_NPUB;
      S_LD_KEY:
        if (key_valid && cnt_q == KEY_LAST) state_d = S_IDLE;
      S_LD_NPUB:
        if (bdi_valid && cnt_q == NPUB_LAST)
          state_d = S_INIT_LOAD;
      S_INIT_LOAD: state_d = S_INIT_PERM;
      S_INIT_PERM: if (done_rise) state_d = S_INIT_LOCK;
      S_INIT_LOCK: state_d = S_CLR;
      S_CLR:
        if (pad_q) state_d = blk_q.msg ? S_TRUNC : S_ABSORB;
        else state_d = S_WAIT_BDI;
      S_WAIT_BDI:
        if (bdi_valid && bdi_type == T_TAG && tag_ph_q)
          state_d = S_LD_TAG;
        else if (close) state_d = msg_now ? S_TRUNC : S_ABSORB;
      S_TRUNC:
        if (trunc_complete)
          state_d = cum_q == '0 ? S_ABSORB : S_OUT_HI;
      S_OUT_HI:
        if (bdo_ready)
          state_d = cum_q <= 4'd4 ? S_ABSORB : S_OUT_LO;
      S_OUT_LO: if (bdo_ready) state_d = S_ABSORB;
      S_ABSORB: state_d = S_PERM;
      S_PERM:
        if (done_rise) begin
          if (!blk_q.last || blk_q.full) state_d = S_CLR;
          else if (!blk_q.msg && !blk_q.eoi) state_d = S_CLR;
          else state_d = S_FINAL_LOCK;
        end
      S_FINAL_LOCK: state_d = S_FINAL_PERM;
      S_FINAL_PERM:
        if (done_rise) state_d = dec_q ? S_CLR : S_TAG_HI;
      S_TAG_HI: if (bdo_ready) state_d = S_TAG_LO;
      S_TAG_LO: if (bdo_ready) state_d = S_IDLE;
      S_LD_TAG:
        if (bdi_valid && cnt_q == 2'd1) state_d = S_VERIFY;
      S_VERIFY: if (msg_auth_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A segment ending on a full block is followed by an empty pad block.
  always_ff @(posedge clk) begin
    if (rst) begin
      cum_q    <= '0;
      blk_q    <= '0;
      pad_q    <= 1'b0;
      tag_ph_q <= 1'b0;
      dec_q    <= 1'b0;
    end else begin
      if (state_q == S_CLR) cum_q <= '0;
      else if (acc) cum_q <= cum_q + {1'b0, bdi_size};
      if (close) begin
        blk_q <= '{last: bdi_eot, full: full_now,
                   eoi: bdi_eoi, msg: msg_now,
                   partial: !full_now};
      end else if (state_q == S_CLR && pad_q) begin
        blk_q.last    <= 1'b1;
        blk_q.full    <= 1'b0;
        blk_q.partial <= 1'b1;
      end
      if (state_q == S_PERM && done_rise
          && blk_q.last && blk_q.full)
        pad_q <= 1'b1;
      else if (state_q == S_CLR) pad_q <= 1'b0;
      if (state_q == S_IDLE) tag_ph_q <= 1'b0;
      else if (state_q == S_FINAL_PERM && done_rise)
        tag_ph_q <= 1'b1;
      if (state_q == S_LD_NPUB && bdi_valid && cnt_q == '0)
        dec_q <= decrypt_in;
    end
  end

  always_comb begin
    key_ready       = 1'b0;
    bdi_ready       = 1'b0;
    bdo_valid       = 1'b0;
    end_of_block    = 1'b0;
    msg_auth_valid  = 1'b0;
    start           = 1'b0;
    init_state      = 1'b0;
    en_key          = 1'b0;
    en_npub         = 1'b0;
    en_bdi          = 1'b0;
    clr_bdi         = 1'b0;
    en_cum_size     = 1'b0;
    en_trunc        = 1'b0;
    init_trunc      = 1'b0;
    bdi_complete    = 1'b0;
    bdo_complete    = 1'b0;
    en_state_in     = 1'b0;
    sel_tag         = 1'b0;
    init_lock       = 1'b0;
    lock_tag_state  = 1'b0;
    ctrl_word       = 2'b00;
    decrypt_reg     = !rst && dec_q;
    bdi_partial_reg = !rst && blk_q.partial;
    if (!rst) begin
      unique case (state_q)
        S_LD_KEY: begin
          key_ready = key_valid;
          en_key    = key_valid;
        end
        S_LD_NPUB: begin
          bdi_ready = bdi_valid;
          en_npub   = bdi_valid;
        end
        S_INIT_LOAD: begin
          init_state  = 1'b1;
          en_state_in = 1'b1;
        end
        S_INIT_PERM, S_PERM, S_FINAL_PERM: start = fresh_q;
        S_INIT_LOCK: begin
          init_lock   = 1'b1;
          en_state_in = 1'b1;
        end
        S_CLR: begin
          clr_bdi     = 1'b1;
          en_bdi      = 1'b1;
          en_cum_size = 1'b1;
          init_trunc  = pad_q && blk_q.msg;
        end
        S_WAIT_BDI: begin
          bdi_ready    = acc;
          en_bdi       = acc;
          en_cum_size  = acc;
          bdi_complete = acc && cnt_q == 2'd1;
          init_trunc   = close && msg_now;
        end
        S_TRUNC: en_trunc = !trunc_complete;
        S_OUT_HI: bdo_valid = 1'b1;
        S_OUT_LO: begin
          bdo_valid    = 1'b1;
          bdo_complete = 1'b1;
        end
        S_ABSORB: begin
          en_state_in = 1'b1;
          ctrl_word   = blk_q.msg ? CW_MSG : CW_AD;
        end
        S_FINAL_LOCK: begin
          lock_tag_state = 1'b1;
          en_state_in    = 1'b1;
        end
        S_TAG_HI: begin
          bdo_valid = 1'b1;
          sel_tag   = 1'b1;
        end
        S_TAG_LO: begin
          bdo_valid    = 1'b1;
          sel_tag      = 1'b1;
          bdo_complete = 1'b1;
          end_of_block = 1'b1;
        end
        S_LD_TAG: begin
          bdi_ready    = bdi_valid;
          en_bdi       = bdi_valid;
          bdi_complete = bdi_valid && cnt_q == 2'd1;
        end
        S_VERIFY: msg_auth_valid = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spoc64_controller.sv
// Directed bench for spoc64_controller.
// A small datapath model answers start/done and truncation.
module tb_spoc64_controller;

  localparam logic [2:0] NPUB = 3'b110;
  localparam logic [2:0] AD   = 3'b001;
  localparam logic [2:0] MSG  = 3'b010;
  localparam logic [2:0] TAG  = 3'b100;

  logic clk = 0, rst = 1;
  logic key_valid = 0, key_update = 0;
  logic bdi_valid = 0, bdi_eot = 0, bdi_eoi = 0;
  logic [2:0] bdi_type = 0, bdi_size = 0;
  logic decrypt_in = 0, bdo_ready = 1;
  logic msg_auth_ready = 0, msg_auth = 0;
  logic done, trunc_complete;
  logic key_ready, bdi_ready, bdo_valid, end_of_block;
  logic msg_auth_valid, start, init_state, en_key;
  logic en_npub, en_bdi, clr_bdi, en_cum_size, en_trunc;
  logic init_trunc, bdi_complete, bdo_complete;
  logic en_state_in, sel_tag, init_lock, lock_tag_state;
  logic decrypt_reg, bdi_partial_reg;
  logic [1:0] ctrl_word;
  logic [23:0] outs;

  int n_checks = 0, n_fail = 0;
  int pc = 0, tcnt = 0, mcum = 0;
  int n_start = 0, n_key = 0, n_bdo = 0, n_bdo_pt = 0;
  int n_eob = 0, eob_at = 0, n_trunc = 0, n_ab = 0;
  logic [1:0] ab_ctrl [64];
  int ab_cum [64];

  always #5 clk = ~clk;

  spoc64_controller dut (
    .clk(clk), .rst(rst),
    .key_valid(key_valid), .key_ready(key_ready),
    .key_update(key_update),
    .bdi_valid(bdi_valid), .bdi_ready(bdi_ready),
    .bdi_type(bdi_type), .bdi_size(bdi_size),
    .bdi_eot(bdi_eot), .bdi_eoi(bdi_eoi),
    .decrypt_in(decrypt_in),
    .bdo_valid(bdo_valid), .bdo_ready(bdo_ready),
    .end_of_block(end_of_block),
    .msg_auth_valid(msg_auth_valid),
    .msg_auth_ready(msg_auth_ready),
    .done(done), .trunc_complete(trunc_complete),
    .msg_auth(msg_auth),
    .start(start), .init_state(init_state),
    .en_key(en_key), .en_npub(en_npub),
    .en_bdi(en_bdi), .clr_bdi(clr_bdi),
    .en_cum_size(en_cum_size), .en_trunc(en_trunc),
    .init_trunc(init_trunc), .bdi_complete(bdi_complete),
    .bdo_complete(bdo_complete), .en_state_in(en_state_in),
    .sel_tag(sel_tag), .init_lock(init_lock),
    .lock_tag_state(lock_tag_state),
    .decrypt_reg(decrypt_reg),
    .bdi_partial_reg(bdi_partial_reg),
    .ctrl_word(ctrl_word)
  );

  assign outs = {key_ready, bdi_ready, bdo_valid,
                 end_of_block, msg_auth_valid, start,
                 init_state, en_key, en_npub, en_bdi,
                 clr_bdi, en_cum_size, en_trunc, init_trunc,
                 bdi_complete, bdo_complete, en_state_in,
                 sel_tag, init_lock, lock_tag_state,
                 decrypt_reg, bdi_partial_reg, ctrl_word};

  // Permutation: done pulses 4 cycles after start.
  // Truncation: 8 - cum_size en_trunc cycles.
  assign done = (pc == 1);
  assign trunc_complete = (tcnt == 8 - mcum);

  always @(posedge clk) begin
    if (rst) begin
      pc <= 0; tcnt <= 0; mcum <= 0;
    end else begin
      if (start) pc <= 4;
      else if (pc != 0) pc <= pc - 1;
      if (init_trunc) tcnt <= 0;
      else if (en_trunc) tcnt <= tcnt + 1;
      if (clr_bdi) mcum <= 0;
      else if (en_cum_size && bdi_ready)
        mcum <= mcum + int'(bdi_size);
    end
    if (start) n_start <= n_start + 1;
    if (en_key) n_key <= n_key + 1;
    if (en_trunc) n_trunc <= n_trunc + 1;
    if (bdo_valid && bdo_ready) begin
      n_bdo <= n_bdo + 1;
      if (!sel_tag) n_bdo_pt <= n_bdo_pt + 1;
      if (end_of_block) begin
        n_eob <= n_eob + 1;
        eob_at <= n_bdo + 1;
      end
    end
    if (en_state_in && ctrl_word != 2'b00) begin
      ab_ctrl[n_ab % 64] <= ctrl_word;
      ab_cum[n_ab % 64] <= mcum;
      n_ab <= n_ab + 1;
    end
  end

  task automatic check_eq(input string tag,
                          input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // All drivers start and end just after a falling edge.
  task automatic send_key();
    int n = 0;
    key_valid = 1; key_update = 1;
    #1;
    while (!key_ready && n < 200) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 200) check_eq("key_timeout", 0, 1);
    @(negedge clk);
    key_valid = 0;
  endtask

  task automatic send_bdi(input logic [2:0] t,
                          input logic [2:0] sz,
                          input logic eot, input logic eoi,
                          input logic dec);
    int n = 0;
    bdi_valid = 1; bdi_type = t; bdi_size = sz;
    bdi_eot = eot; bdi_eoi = eoi; decrypt_in = dec;
    #1;
    while (!bdi_ready && n < 200) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 200) check_eq("bdi_timeout", 0, 1);
    @(negedge clk);
    bdi_valid = 0; bdi_eot = 0; bdi_eoi = 0;
  endtask

  task automatic send_npub(input logic dec);
    for (int i = 0; i < 4; i++) send_bdi(NPUB, 3'd4, i == 3, 0, dec);
  endtask

  task automatic wait_eob(input int e0);
    int n = 0;
    while (n_eob == e0 && n < 400) begin
      @(negedge clk); n++;
    end
    check_eq("eob_seen", n_eob - e0, 1);
  endtask

  task automatic run_decrypt(input logic good);
    int n = 0;
    int b0, e0;
    b0 = n_bdo; e0 = n_eob;
    msg_auth = good;
    send_npub(1);
    send_bdi(MSG, 3'd3, 1, 1, 1);
    send_bdi(TAG, 3'd4, 0, 0, 1);
    send_bdi(TAG, 3'd4, 1, 1, 1);
    while (!msg_auth_valid && n < 200) begin
      @(negedge clk); n++;
    end
    check_eq("auth_valid_seen", msg_auth_valid, 1);
    check_eq("decrypt_reg", decrypt_reg, 1);
    n = 0;
    repeat (3) begin
      @(negedge clk);
      if (msg_auth_valid) n++;
    end
    check_eq("auth_valid_hold", n, 3);
    msg_auth_ready = 1;
    @(negedge clk);
    msg_auth_ready = 0;
    check_eq("auth_released", msg_auth_valid, 0);
    check_eq("dec_bdo_words", n_bdo - b0, 1);
    check_eq("dec_no_eob", n_eob - e0, 0);
  endtask

  initial begin
    int n, bad, s0, b0, e0, k0, a0, t0, p0;

    repeat (3) @(negedge clk);
    rst = 0;
    #1 check_eq("reset_outs", outs, 0);

    // Key load.
    k0 = n_key;
    for (int i = 0; i < 4; i++) send_key();
    key_update = 0;
    check_eq("key_words", n_key - k0, 4);

    // Encrypt, no AD, 8-byte PT, with output stall.
    s0 = n_start; b0 = n_bdo; e0 = n_eob;
    bdo_ready = 0;
    send_npub(0);
    send_bdi(MSG, 3'd4, 0, 0, 0);
    send_bdi(MSG, 3'd4, 1, 1, 0);
    n = 0;
    while (!bdo_valid && n < 200) begin
      @(negedge clk); n++;
    end
    check_eq("bdo_seen", bdo_valid, 1);
    check_eq("first_word_hi", {bdo_complete, sel_tag}, 0);
    bad = 0;
    bdi_valid = 1; bdi_type = AD; bdi_size = 3'd4;
    repeat (10) begin
      #1;
      if (!bdo_valid || bdi_ready || start || en_bdi
          || en_trunc || en_state_in || bdo_complete)
        bad++;
      @(negedge clk);
    end
    bdi_valid = 0;
    bdo_ready = 1;
    check_eq("stall_bad", bad, 0);
    wait_eob(e0);
    check_eq("a_starts", n_start - s0, 4);
    check_eq("a_bdo_words", n_bdo - b0, 4);
    check_eq("a_eob_index", eob_at - b0, 4);

    // Encrypt with stored key, AD 5 bytes, PT 3 bytes.
    k0 = n_key; s0 = n_start; b0 = n_bdo; e0 = n_eob;
    a0 = n_ab; t0 = n_trunc; p0 = n_bdo_pt;
    send_npub(0);
    send_bdi(AD, 3'd4, 0, 0, 0);
    send_bdi(AD, 3'd1, 1, 0, 0);
    send_bdi(MSG, 3'd3, 1, 1, 0);
    wait_eob(e0);
    check_eq("b_no_key", n_key - k0, 0);
    check_eq("b_starts", n_start - s0, 4);
    check_eq("b_bdo_words", n_bdo - b0, 3);
    check_eq("b_pt_words", n_bdo_pt - p0, 1);
    check_eq("b_trunc_cycles", n_trunc - t0, 5);
    check_eq("b_ad_ctrl", ab_ctrl[a0 % 64], 2'b01);
    check_eq("b_ad_cum", ab_cum[a0 % 64], 5);
    check_eq("b_pt_ctrl", ab_ctrl[(a0 + 1) % 64], 2'b10);
    check_eq("b_pt_cum", ab_cum[(a0 + 1) % 64], 3);

    // Decrypt, good tag then flipped tag.
    run_decrypt(1);
    run_decrypt(0);

    // Reset during the init permutation.
    s0 = n_start;
    send_npub(0);
    n = 0;
    while (n_start == s0 && n < 50) begin
      @(negedge clk); n++;
    end
    check_eq("init_start_seen", n_start - s0, 1);
    rst = 1;
    #1 check_eq("rst_cycle_outs", outs, 0);
    @(negedge clk);
    rst = 0;
    #1 check_eq("rst_after_outs", outs, 0);
    @(negedge clk);
    s0 = n_start;
    send_npub(0);
    n = 0;
    while (n_start == s0 && n < 50) begin
      @(negedge clk); n++;
    end
    check_eq("restart_start", n_start - s0, 1);

    rst = 1;
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
